fetch_queue: RTL and testbench

Parametrised front-end fetch stage that replaces the free-running testbench program counter. It owns the PC and issues requests to the synchronous instruction memory (instr_fetch, 1-cycle read latency). Returned words are buffered in a DEPTH-entry FIFO that feeds decode/rename through a valid/stall handshake. It also supports redirect (flush + new PC), so rename back-pressure and branch redirects no longer corrupt the instruction stream.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_queue_if.sv | 54 +++++
 rtl/fetch_queue_sync_fifo.sv | 59 +++++
 rtl/fetch_queue.sv | 86 ++++++++
 tb/tb_fetch_queue.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch constants and the queue entry type.
// Used by fetch_queue, decode and the pipeline benches.
package fetch_pkg;

  localparam int INSTR_W  = 32;
  localparam int PC_MAX_W = 32;
  localparam int PC_STEP  = 4;

  localparam logic [INSTR_W-1:0] NOP_INSTR =
    32'h0000_0013;

  // pc is stored at full width so decode can
  // share the type regardless of ADDR_W.
  typedef struct packed {
    logic [INSTR_W-1:0]  instr;
    logic [PC_MAX_W-1:0] pc;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: IMEM request/response and decode-side handshake.
// master = fetch_queue, slave = IMEM + decode (or a bench).
//   imem_addr/imem_req   -> request to instr_fetch
//   imem_data            <- read data, one cycle after request
//   stall_in             <- downstream back-pressure
//   redirect_valid/_pc   <- flush and restart fetch
//   out_valid/instr/pc   -> queue head
//   out_count            -> queue occupancy
interface fetch_queue_if #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
);
  import fetch_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_req;
  logic [INSTR_W-1:0] imem_data;
  logic               stall_in;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic [CNT_W-1:0]   out_count;

  modport master (
    output imem_addr,
    output imem_req,
    input  imem_data,
    input  stall_in,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    output out_instr,
    output out_pc,
    output out_count
  );

  modport slave (
    input  imem_addr,
    input  imem_req,
    output imem_data,
    output stall_in,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    input  out_instr,
    input  out_pc,
    input  out_count
  );

endinterface

// File: rtl/fetch_queue_sync_fifo.sv
// sync_fifo: power-of-two synchronous FIFO with flush.
// Ports: clk, rst_n (async, active-low), i_push, i_pop, i_flush,
//   i_data -> written at tail, o_head -> head entry, o_count.
// Caller guarantees no push when full and no pop when empty.
module sync_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;

  // Pointers are exactly AW bits wide, so the
  // natural overflow is the modulo-DEPTH wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + AW'(1);
      end
      if (i_pop) begin
        r_rd <= r_rd + AW'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: PC owner, IMEM request issue and instruction queue.
// Ports: clk, rst (async, active-low), bus (fetch_queue_if.master).
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              ADDR_W   = 8,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int UW    = CNT_W + 1;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_inflight_pc;
  logic              r_inflight;

  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_valid;
  logic [CNT_W-1:0]  w_count;
  logic [UW-1:0]     w_used;
  fq_entry_t         w_in;
  fq_entry_t         w_head;
  logic              w_unused;

  // An in-flight request already owns a slot, so
  // only registered state counts toward credit.
  assign w_used  = {1'b0, w_count} + UW'(r_inflight);
  assign w_issue = rst && !bus.redirect_valid &&
                   (w_used < UW'(DEPTH));
  assign w_push  = r_inflight && !bus.redirect_valid;
  assign w_valid = (w_count != '0);
  assign w_pop   = w_valid && !bus.stall_in &&
                   !bus.redirect_valid;

  assign w_in = {bus.imem_data,
                 PC_MAX_W'(r_inflight_pc)};

  sync_fifo #(
    .WIDTH ($bits(fq_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.redirect_valid),
    .i_data  (w_in),
    .o_head  (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (bus.redirect_valid) begin
      r_pc       <= {bus.redirect_pc[ADDR_W-1:2], 2'b00};
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_pc          <= r_pc + ADDR_W'(PC_STEP);
        r_inflight_pc <= r_pc;
      end
    end
  end

  assign bus.imem_addr = r_pc;
  assign bus.imem_req  = w_issue;
  assign bus.out_valid = w_valid;
  assign bus.out_count = w_count;
  assign bus.out_instr = w_valid ? w_head.instr : '0;
  assign bus.out_pc    = w_valid ?
                         w_head.pc[ADDR_W-1:0] : '0;

  assign w_unused = ^{w_head.pc, bus.redirect_pc[1:0]};

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue with a
// queue-based reference model checked every cycle.
module tb_fetch_queue;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus();

  fetch_queue #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (8'h00)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [64];

  always @(posedge clk) begin
    if (bus.imem_req) begin
      bus.imem_data <= mem[bus.imem_addr[7:2]];
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t",
               name, got, exp, $time);
    end
  endtask

  // Reference model: what should be in the queue,
  // the next fetch PC and an outstanding request.
  typedef struct {
    logic [31:0] instr;
    int          pc;
  } ent_t;

  ent_t q[$];
  ent_t m_e;
  int   m_pc      = 0;
  bit   m_pend    = 0;
  int   m_pend_pc = 0;
  bit   m_pop;
  bit   m_iss;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_pc   = 0;
      m_pend = 0;
    end else if (bus.redirect_valid) begin
      q.delete();
      m_pend = 0;
      m_pc   = int'(bus.redirect_pc) & ~3;
    end else begin
      m_pop = (q.size() != 0) && !bus.stall_in;
      m_iss = (q.size() + int'(m_pend)) < DEPTH;
      if (m_pop) void'(q.pop_front());
      if (m_pend) begin
        m_e.instr = mem[m_pend_pc / 4];
        m_e.pc    = m_pend_pc;
        q.push_back(m_e);
      end
      m_pend = m_iss;
      if (m_iss) begin
        m_pend_pc = m_pc;
        m_pc      = (m_pc + 4) % 256;
      end
    end
  end

  logic exp_req;

  always @(negedge clk) begin
    exp_req = rst && !bus.redirect_valid &&
              ((q.size() + int'(m_pend)) < DEPTH);
    chk("m_req",   32'(bus.imem_req),  32'(exp_req));
    chk("m_addr",  32'(bus.imem_addr), 32'(m_pc));
    chk("m_valid", 32'(bus.out_valid),
        32'(q.size() != 0));
    chk("m_count", 32'(bus.out_count), 32'(q.size()));
    if (q.size() != 0) begin
      chk("m_instr", bus.out_instr,     q[0].instr);
      chk("m_pc",    32'(bus.out_pc),   32'(q[0].pc));
    end else begin
      chk("m_instr0", bus.out_instr,    32'h0);
      chk("m_pc0",    32'(bus.out_pc),  32'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] wrap_pcs [4];

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'hA000_0000 | 32'(i);
    end
    mem[0] = 32'h0060_0113;
    mem[1] = 32'h00f0_0193;
    wrap_pcs[0] = 8'hF8;
    wrap_pcs[1] = 8'hFC;
    wrap_pcs[2] = 8'h00;
    wrap_pcs[3] = 8'h04;
    bus.stall_in       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    // reset state
    repeat (2) tick();
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_count", 32'(bus.out_count), 32'h0);
    chk("rst_req",   32'(bus.imem_req),  32'h0);
    chk("rst_instr", bus.out_instr,      32'h0);
    chk("rst_pc",    32'(bus.out_pc),    32'h0);

    // first two instructions after reset
    rst = 1'b1;
    tick();
    chk("t1_valid0", 32'(bus.out_valid), 32'h0);
    chk("t1_addr",   32'(bus.imem_addr), 32'h4);
    tick();
    chk("t1_valid",  32'(bus.out_valid), 32'h1);
    chk("t1_instr0", bus.out_instr,      32'h0060_0113);
    chk("t1_pc0",    32'(bus.out_pc),    32'h0);
    tick();
    chk("t1_instr1", bus.out_instr,      32'h00f0_0193);
    chk("t1_pc1",    32'(bus.out_pc),    32'h4);

    // stall from reset until full, then drain
    rst = 1'b0;
    bus.stall_in = 1'b1;
    tick();
    rst = 1'b1;
    repeat (10) tick();
    chk("t2_count", 32'(bus.out_count), 32'h4);
    chk("t2_req",   32'(bus.imem_req),  32'h0);
    chk("t2_addr",  32'(bus.imem_addr), 32'h10);
    bus.stall_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t2_seq_valid", 32'(bus.out_valid), 32'h1);
      chk("t2_seq_pc",    32'(bus.out_pc),    32'(4 * i));
      tick();
    end

    // redirect with 3 queued and one in flight
    bus.stall_in = 1'b1;
    tick();
    chk("t3_count3", 32'(bus.out_count), 32'h3);
    chk("t3_req0",   32'(bus.imem_req),  32'h0);
    bus.stall_in       = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'h23;
    #1;
    chk("t3_req_rd", 32'(bus.imem_req), 32'h0);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk("t3_valid0", 32'(bus.out_valid), 32'h0);
    chk("t3_count0", 32'(bus.out_count), 32'h0);
    chk("t3_addr",   32'(bus.imem_addr), 32'h20);
    chk("t3_req1",   32'(bus.imem_req),  32'h1);
    tick();
    chk("t3_valid1", 32'(bus.out_valid), 32'h0);
    tick();
    chk("t3_valid2", 32'(bus.out_valid), 32'h1);
    chk("t3_pc",     32'(bus.out_pc),    32'h20);
    chk("t3_instr",  bus.out_instr,      32'hA000_0008);

    // push and pop together at count 2
    bus.stall_in = 1'b1;
    tick();
    bus.stall_in = 1'b0;
    #1;
    chk("t4_count_a", 32'(bus.out_count), 32'h2);
    chk("t4_pc_a",    32'(bus.out_pc),    32'h20);
    tick();
    chk("t4_count_b", 32'(bus.out_count), 32'h2);
    chk("t4_pc_b",    32'(bus.out_pc),    32'h24);
    tick();
    chk("t4_count_c", 32'(bus.out_count), 32'h2);
    chk("t4_pc_c",    32'(bus.out_pc),    32'h28);

    // PC wrap
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'hF8;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_valid", 32'(bus.out_valid), 32'h1);
      chk("t5_pc",    32'(bus.out_pc),    32'(wrap_pcs[i]));
    end

    // async reset with a full queue
    bus.stall_in = 1'b1;
    repeat (6) tick();
    chk("t6_full", 32'(bus.out_count), 32'h4);
    #1;
    rst = 1'b0;
    #1;
    chk("t6_valid", 32'(bus.out_valid), 32'h0);
    chk("t6_count", 32'(bus.out_count), 32'h0);
    chk("t6_req",   32'(bus.imem_req),  32'h0);
    bus.stall_in = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("t6_addr",   32'(bus.imem_addr), 32'h4);
    chk("t6_valid0", 32'(bus.out_valid), 32'h0);
    tick();
    chk("t6_valid1", 32'(bus.out_valid), 32'h1);
    chk("t6_pc",     32'(bus.out_pc),    32'h0);
    chk("t6_instr",  bus.out_instr,      32'h0060_0113);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
